regfile_dump_reader: RTL and testbench

Sequential read-side client of the 32×64 register file: on command, walks all 32 architectural registers through the file's two combinational read ports (RA/RB → BusA/BusB) and streams each value, tagged with its index, over a valid/ready output channel. It sits beside the datapath and drives RA/RB only while the datapath is halted. It serves debug register dumps, context save and simulation scoreboarding. Register 31 reads as zero from the file and is streamed as zero.

---
 rtl/regfile_reader_pkg.sv | 19 +
 rtl/regfile_pair_buffer.sv | 46 ++++
 rtl/regfile_dump_reader.sv | 111 +++++++++++
 tb/tb_regfile_dump_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// regfile_reader_pkg: shared types and default sizes for the register-file
// dump reader. Holds the FSM state encoding, the default widths of the
// 32x64 register file and the index of the hard-wired zero register.
package regfile_reader_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_pair_buffer.sv
// regfile_pair_buffer: captures one even/odd register pair from the two
// register-file read ports and presents one of the two words on the output.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   capture_i        load bus_a_i/bus_b_i into the pair buffers
//   rb_i             odd read address; the zero register is stored as zero
//   bus_a_i/bus_b_i  register-file read data (even / odd)
//   sel_i            0 = present even word, 1 = present odd word
//   pair_i           pair number, forms the upper index bits
//   data_o/index_o   selected word and its register index
module regfile_pair_buffer
  import regfile_reader_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_reader_pkg::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  capture_i,
  input  logic [ADDR_WIDTH-1:0] rb_i,
  input  logic [DATA_WIDTH-1:0] bus_a_i,
  input  logic [DATA_WIDTH-1:0] bus_b_i,
  input  logic                  sel_i,
  input  logic [ADDR_WIDTH-2:0] pair_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] index_o
);

  logic [DATA_WIDTH-1:0] buf0_q;
  logic [DATA_WIDTH-1:0] buf1_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else if (capture_i) begin
      buf0_q <= bus_a_i;
      // Register 31 is streamed as zero regardless of what the bus shows.
      buf1_q <= (rb_i == ADDR_WIDTH'(ZERO_REG)) ? '0 : bus_b_i;
    end
  end

  assign data_o  = sel_i ? buf1_q : buf0_q;
  assign index_o = {pair_i, sel_i};

endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks all registers of the register file two at a time
// through its read ports and streams each value with its index over a
// valid/ready channel.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Start, Abort      begin a dump (IDLE only) / cancel a dump
//   Busy, Done        not-idle flag / one-cycle completion pulse
//   RA, RB            registered read addresses (even / odd)
//   BusA, BusB        register-file read data
//   OutValid/OutReady output handshake
//   OutData/OutIndex  register value and its index
//   DbgState          current FSM state
//
// Handshake: a beat transfers on a rising edge where OutValid and OutReady are
// both high. OutValid never depends on OutReady, and OutData/OutIndex hold
// while OutValid is high and OutReady low; only Abort or Reset withdraw a beat.
module regfile_dump_reader
  import regfile_reader_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_reader_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_reader_pkg::NUM_REGS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] RA,
  output logic [ADDR_WIDTH-1:0] RB,
  input  logic [DATA_WIDTH-1:0] BusA,
  input  logic [DATA_WIDTH-1:0] BusB,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [ADDR_WIDTH-1:0] OutIndex,
  output state_e                DbgState
);

  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [PW-1:0] LAST_P = PW'(NUM_REGS / 2 - 1);

  state_e                state_q;
  logic [PW-1:0]         p_q;
  logic [ADDR_WIDTH-1:0] ra_q;
  logic [ADDR_WIDTH-1:0] rb_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else if (Abort && (state_q != IDLE)) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Start together with Abort is treated as no request.
          if (Start && !Abort) begin
            state_q <= READ;
            p_q     <= '0;
            ra_q    <= '0;
            rb_q    <= ADDR_WIDTH'(1);
          end
        end
        READ:  state_q <= SEND0;
        SEND0: if (OutReady) state_q <= SEND1;
        SEND1: begin
          if (OutReady) begin
            if (p_q == LAST_P) begin
              state_q <= DONE;
            end else begin
              p_q     <= p_q + 1'b1;
              ra_q    <= {p_q + 1'b1, 1'b0};
              rb_q    <= {p_q + 1'b1, 1'b1};
              state_q <= READ;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign OutValid = (state_q == SEND0) || (state_q == SEND1);
  assign RA       = ra_q;
  assign RB       = rb_q;
  assign DbgState = state_q;

  regfile_pair_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pair_buffer (
    .clk_i    (Clk),
    .reset_i  (Reset),
    .capture_i(state_q == READ),
    .rb_i     (rb_q),
    .bus_a_i  (BusA),
    .bus_b_i  (BusB),
    .sel_i    (state_q == SEND1),
    .pair_i   (p_q),
    .data_o   (OutData),
    .index_o  (OutIndex)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  import regfile_reader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, out_ready;
  logic        busy, done, out_valid;
  logic [4:0]  ra, rb, out_index;
  logic [63:0] bus_a, bus_b, out_data;
  state_e      dbg_state;

  logic [63:0] rf [32];
  assign bus_a = (ra == 5'd31) ? 64'd0 : rf[ra];
  assign bus_b = (rb == 5'd31) ? 64'd0 : rf[rb];

  regfile_dump_reader dut (
    .Clk(clk), .Reset(reset), .Start(start), .Abort(abort),
    .Busy(busy), .Done(done), .RA(ra), .RB(rb),
    .BusA(bus_a), .BusB(bus_b),
    .OutValid(out_valid), .OutReady(out_ready),
    .OutData(out_data), .OutIndex(out_index), .DbgState(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int beat_cnt = 0;
  logic [68:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({5'(i), (i == 31) ? 64'd0 : rf[i]});
  endtask

  // Monitor: inputs change #1 after posedge, so negedge sees what the
  // next posedge will consume.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [4:0]  prev_idx, prev_ra, prev_rb;
  always @(negedge clk) begin
    logic [68:0] e;
    if (!reset && !abort && out_valid) begin
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_index", 64'(out_index), 64'(prev_idx));
        check("stall_ra", 64'(ra), 64'(prev_ra));
        check("stall_rb", 64'(rb), 64'(prev_rb));
      end
      if (out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(out_index), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_index", 64'(out_index), 64'(e[68:64]));
          check("beat_data", out_data, e[63:0]);
        end
      end
    end
    prev_stall = !reset && !abort && out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_index;
    prev_ra    = ra;
    prev_rb    = rb;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in cycle 1 (just after edge E0 that sampled Start).
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(out_valid && out_index == 5'(idx)) && n < 500) begin
      cyc(1);
      n++;
    end
    check("wait_idx_timeout", 64'(n < 500), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      if (out_ready !== 1'b1 || $urandom_range(0, 1) == 0) out_ready = 1'b1;
      cyc(1);
      n++;
    end
    check("wait_done_timeout", 64'(n < 3000), 64'd1);
    cyc(1);
  endtask

  task automatic wr_reg(input int idx, input logic [63:0] val);
    @(negedge clk);
    rf[idx] = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cyc(2);
    // reset values
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_index", 64'(out_index), 0);
    check("rst_ra", 64'(ra), 0);
    check("rst_rb", 64'(rb), 0);
    reset = 1'b0;
    cyc(1);

    // Full dump, OutReady high: Done in cycle 49, idle in cycle 50.
    out_ready = 1'b1;
    beat_cnt = 0;
    push_dump();
    pulse_start();
    for (int k = 1; k <= 50; k++) begin
      check($sformatf("busy_c%0d", k), 64'(busy), 64'(k <= 49));
      check($sformatf("done_c%0d", k), 64'(done), 64'(k == 49));
      if (k == 1) check("valid_c1", 64'(out_valid), 0);
      if (k == 2) check("valid_c2", 64'(out_valid), 1);
      cyc(1);
    end
    check("full_beats", 64'(beat_cnt), 32);
    check("full_q_empty", 64'(exp_q.size()), 0);

    // Backpressure with pseudo-random OutReady.
    beat_cnt = 0;
    push_dump();
    pulse_start();
    begin
      int n = 0;
      while (!done && n < 3000) begin
        out_ready = ($urandom_range(0, 2) != 0);
        cyc(1);
        n++;
      end
      check("bp_timeout", 64'(n < 3000), 1);
    end
    out_ready = 1'b1;
    cyc(2);
    check("bp_beats", 64'(beat_cnt), 32);
    check("bp_q_empty", 64'(exp_q.size()), 0);

    // Abort during SEND1 of pair 5 (index 11 presented).
    push_dump();
    pulse_start();
    wait_idx(11);
    abort = 1'b1;
    out_ready = 1'b0;
    cyc(1);
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    for (int k = 0; k < 3; k++) begin
      check("abort_no_done", 64'(done), 0);
      cyc(1);
    end
    check("abort_q_left", 64'(exp_q.size()), 21);
    exp_q.delete();
    out_ready = 1'b1;
    beat_cnt = 0;
    push_dump();
    pulse_start();
    wait_done();
    check("after_abort_beats", 64'(beat_cnt), 32);
    check("after_abort_q", 64'(exp_q.size()), 0);

    // Reset mid-dump at pair 9, Start held during reset.
    push_dump();
    pulse_start();
    wait_idx(18);
    reset = 1'b1;
    start = 1'b1;
    out_ready = 1'b0;
    cyc(1);
    check("mrst_busy", 64'(busy), 0);
    check("mrst_done", 64'(done), 0);
    check("mrst_valid", 64'(out_valid), 0);
    check("mrst_data", out_data, 0);
    check("mrst_index", 64'(out_index), 0);
    check("mrst_ra", 64'(ra), 0);
    check("mrst_rb", 64'(rb), 0);
    cyc(1);
    check("mrst_busy2", 64'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    cyc(1);
    check("mrst_after", 64'(busy), 0);
    exp_q.delete();

    // Start pulsed while busy: no restart.
    out_ready = 1'b1;
    beat_cnt = 0;
    push_dump();
    pulse_start();
    cyc(10);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done();
    check("busy_start_beats", 64'(beat_cnt), 32);
    check("busy_start_q", 64'(exp_q.size()), 0);
    check("busy_start_idle", 64'(busy), 0);

    // Start and Abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    cyc(1);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 64'(busy), 0);
    cyc(1);
    check("sa_valid", 64'(out_valid), 0);

    // Write reg[20] during pair 3; pair 10 is captured afterwards.
    beat_cnt = 0;
    push_dump();
    pulse_start();
    wait_idx(6);
    wr_reg(20, 64'h1234);
    foreach (exp_q[i])
      if (exp_q[i][68:64] == 5'd20) exp_q[i][63:0] = 64'h1234;
    @(posedge clk);
    #1;
    wait_done();
    check("wr_beats", 64'(beat_cnt), 32);
    check("wr_q_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
